// File: rtl/tag_ram_lookup_if.sv
// Lookup/write request and lookup-result bundle for tag_ram_lookup.
// The master issues lookups and tag writes; the slave (the tag RAM) returns ready and results.
interface tag_ram_lookup_if #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 13,
    parameter int WAYS   = 2
);
    localparam int WWIDTH = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              lkp_valid;
    logic [AWIDTH-1:0] lkp_addr;
    logic [TWIDTH-1:0] lkp_tag;
    logic              wr_en;
    logic              wr_inv;
    logic [WWIDTH-1:0] wr_way;
    logic [AWIDTH-1:0] wr_addr;
    logic [TWIDTH-1:0] wr_tag;
    logic              ready;
    logic              hit_valid;
    logic              hit;
    logic [WWIDTH-1:0] hit_way;
    logic              multi_hit;

    modport master (
        output lkp_valid, lkp_addr, lkp_tag,
        output wr_en, wr_inv, wr_way, wr_addr, wr_tag,
        input  ready, hit_valid, hit, hit_way, multi_hit
    );

    modport slave (
        input  lkp_valid, lkp_addr, lkp_tag,
        input  wr_en, wr_inv, wr_way, wr_addr, wr_tag,
        output ready, hit_valid, hit, hit_way, multi_hit
    );
endinterface

// File: rtl/tag_ram_lookup.sv
// WAYS-way set-associative tag store: DEPTH-cycle valid-clear after reset, one-cycle lookups.
// Define TAG_RAM_WR_BYPASS_EN to forward a same-edge write into a same-set lookup result.
module tag_ram_lookup #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 13,
    parameter int WAYS   = 2
) (
    input logic             clock,
    input logic             reset_n,
    tag_ram_lookup_if.slave bus
);
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int WWIDTH = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;
    logic              hit_valid_q, hit_valid_d;

    logic [DEPTH-1:0]  valid_q [WAYS];
    logic [DEPTH-1:0]  valid_d [WAYS];
    logic [TWIDTH-1:0] tag_q   [WAYS][DEPTH];
    logic [TWIDTH-1:0] tag_d   [WAYS][DEPTH];

    logic [TWIDTH-1:0] lkp_tag_q, lkp_tag_d;
    logic [WAYS-1:0]   rd_valid_q, rd_valid_d;
    logic [TWIDTH-1:0] rd_tag_q [WAYS];
    logic [TWIDTH-1:0] rd_tag_d [WAYS];

    logic              lkp_acc;
    logic              wr_acc;
    logic [WAYS-1:0]   match;
    logic [WWIDTH-1:0] hit_way_c;

    // A request coinciding with reset is dropped, not half-applied.
    assign lkp_acc = bus.lkp_valid & ready_q & reset_n;
    assign wr_acc  = bus.wr_en & ready_q & reset_n;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == AWIDTH'(DEPTH - 1)) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (state_q == ST_INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_d[w][init_cnt_q] = 1'b0;
            end
        end else if (wr_acc) begin
            valid_d[bus.wr_way][bus.wr_addr] = ~bus.wr_inv;
            if (!bus.wr_inv) begin
                tag_d[bus.wr_way][bus.wr_addr] = bus.wr_tag;
            end
        end
    end

    // Entry contents are captured on the accepting edge, so a same-edge write is not seen unless forwarded.
    always_comb begin
        hit_valid_d = lkp_acc;
        lkp_tag_d   = lkp_tag_q;
        rd_valid_d  = rd_valid_q;
        rd_tag_d    = rd_tag_q;
        if (lkp_acc) begin
            lkp_tag_d = bus.lkp_tag;
            for (int w = 0; w < WAYS; w++) begin
                rd_valid_d[w] = valid_q[w][bus.lkp_addr];
                rd_tag_d[w]   = tag_q[w][bus.lkp_addr];
`ifdef TAG_RAM_WR_BYPASS_EN
                if (wr_acc && (bus.wr_addr == bus.lkp_addr) && (bus.wr_way == WWIDTH'(w))) begin
                    rd_valid_d[w] = ~bus.wr_inv;
                    if (!bus.wr_inv) begin
                        rd_tag_d[w] = bus.wr_tag;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            hit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ready_q     <= ready_d;
            hit_valid_q <= hit_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        valid_q    <= valid_d;
        tag_q      <= tag_d;
        lkp_tag_q  <= lkp_tag_d;
        rd_valid_q <= rd_valid_d;
        rd_tag_q   <= rd_tag_d;
    end

    always_comb begin
        match     = '0;
        hit_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = rd_valid_q[w] && (rd_tag_q[w] == lkp_tag_q);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way_c = WWIDTH'(w);
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit       = hit_valid_q & (|match);
    assign bus.multi_hit = hit_valid_q & ($countones(match) > 1);
    assign bus.hit_way   = hit_valid_q ? hit_way_c : '0;
endmodule

// File: tb/tb_tag_ram_lookup.sv
// Self-checking bench for tag_ram_lookup: directed scenarios plus randomized traffic
// against an associative reference model of the tag store.
module tb_tag_ram_lookup;
    localparam int AWIDTH = 3;
    localparam int TWIDTH = 13;
    localparam int WAYS   = 2;
    localparam int DEPTH  = 8;
    localparam int WWIDTH = 1;
`ifdef TAG_RAM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    tag_ram_lookup_if #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH), .WAYS(WAYS)) bus ();
    tag_ram_lookup #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH), .WAYS(WAYS)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-way, per-set {valid, tag}.
    bit              m_valid [WAYS][DEPTH];
    bit [TWIDTH-1:0] m_tag   [WAYS][DEPTH];
    int              init_wr_addr[$];
    bit [TWIDTH-1:0] init_wr_tag[$];

    function automatic void model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int a = 0; a < DEPTH; a++) m_valid[w][a] = 1'b0;
    endfunction

    function automatic void model_write(input int way, input int a, input bit inv, input bit [TWIDTH-1:0] t);
        if (inv) m_valid[way][a] = 1'b0;
        else begin
            m_valid[way][a] = 1'b1;
            m_tag[way][a]   = t;
        end
    endfunction

    function automatic void model_lookup(input int a, input bit [TWIDTH-1:0] t,
                                         output bit h, output int way, output bit multi);
        int n = 0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][a] && m_tag[w][a] == t) begin
                if (n == 0) way = w;
                n++;
            end
        end
        h = (n > 0);
        multi = (n > 1);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lkp_valid = 1'b0;
        bus.lkp_addr  = '0;
        bus.lkp_tag   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_inv    = 1'b0;
        bus.wr_way    = '0;
        bus.wr_addr   = '0;
        bus.wr_tag    = '0;
    endtask

    task automatic drive_write(input int way, input int a, input bit inv, input bit [TWIDTH-1:0] t);
        bus.wr_en   = 1'b1;
        bus.wr_inv  = inv;
        bus.wr_way  = WWIDTH'(way);
        bus.wr_addr = AWIDTH'(a);
        bus.wr_tag  = t;
    endtask

    task automatic drive_lookup(input int a, input bit [TWIDTH-1:0] t);
        bus.lkp_valid = 1'b1;
        bus.lkp_addr  = AWIDTH'(a);
        bus.lkp_tag   = t;
    endtask

    // Reset has just been released: count not-ready cycles, optionally hammering the inputs.
    task automatic run_init(input string name, input bit traffic);
        int cyc = 0;
        init_wr_addr.delete();
        init_wr_tag.delete();
        while (bus.ready !== 1'b1 && cyc < 20) begin
            if (traffic) begin
                drive_lookup($urandom_range(0, DEPTH - 1), TWIDTH'($urandom_range(0, 3)));
                drive_write($urandom_range(0, WAYS - 1), $urandom_range(0, DEPTH - 1), 1'b0,
                            TWIDTH'($urandom_range(0, 3)));
                init_wr_addr.push_back(int'(bus.wr_addr));
                init_wr_tag.push_back(bus.wr_tag);
            end
            step();
            cyc++;
            checks++;
            if (bus.hit_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_init_no_pulse cycle %0d: hit_valid=%b want 0", name, cyc, bus.hit_valid);
            end
        end
        idle_inputs();
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL %s_init_length: ready low for %0d cycles, want %0d", name, cyc, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.ready !== 1'b0 || bus.hit_valid !== 1'b0 || bus.hit !== 1'b0 ||
            bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b hv=%b hit=%b way=%0d multi=%b want all 0",
                     bus.ready, bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
        reset_n = 1'b1;
        run_init("reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < DEPTH; a++) begin
            drive_lookup(a, TWIDTH'($urandom));
            step();
            checks++;
            if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
                errors++;
                $display("FAIL b2b_empty set %0d: hv=%b hit=%b way=%0d multi=%b want hv=1 hit=0 way=0 multi=0",
                         a, bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
            end
        end
        idle_inputs();
        step();
        checks++;
        if (bus.hit_valid !== 1'b0 || bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse_end: hv=%b hit=%b want 0 0", bus.hit_valid, bus.hit);
        end
    endtask

    task automatic test_single_hit();
        drive_write(1, 5, 1'b0, 13'h0ABC);
        model_write(1, 5, 1'b0, 13'h0ABC);
        step();
        idle_inputs();
        drive_lookup(5, 13'h0ABC);
        step();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 1'b1 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL single_hit: hv=%b hit=%b way=%0d multi=%b want 1 1 1 0",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
        drive_lookup(5, 13'h0ABD);
        step();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL single_miss_tag: hv=%b hit=%b way=%0d multi=%b want 1 0 0 0",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
        idle_inputs();
        step();
        checks++;
        if (bus.hit_valid !== 1'b0 || bus.hit !== 1'b0 || bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: hv=%b hit=%b way=%0d multi=%b want all 0",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
    endtask

    task automatic test_multi_hit();
        drive_write(0, 2, 1'b0, 13'h1234);
        model_write(0, 2, 1'b0, 13'h1234);
        step();
        drive_write(1, 2, 1'b0, 13'h1234);
        model_write(1, 2, 1'b0, 13'h1234);
        step();
        idle_inputs();
        drive_lookup(2, 13'h1234);
        step();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 1'b0 || bus.multi_hit !== 1'b1) begin
            errors++;
            $display("FAIL multi_hit: hv=%b hit=%b way=%0d multi=%b want 1 1 0 1",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
        idle_inputs();
        drive_write(0, 2, 1'b1, 13'h1FFF);
        model_write(0, 2, 1'b1, 13'h1FFF);
        step();
        idle_inputs();
        drive_lookup(2, 13'h1234);
        step();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 1'b1 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL after_inv: hv=%b hit=%b way=%0d multi=%b want 1 1 1 0",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
        end
        drive_lookup(5, 13'h0ABC);
        step();
        checks++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 1'b1 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL other_set_intact: hit=%b way=%0d multi=%b want 1 1 0", bus.hit, bus.hit_way, bus.multi_hit);
        end
        idle_inputs();
    endtask

    task automatic test_same_edge();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        run_init("same_edge", 1'b0);
        drive_write(0, 3, 1'b0, 13'h0055);
        drive_lookup(3, 13'h0055);
        model_write(0, 3, 1'b0, 13'h0055);
        step();
        idle_inputs();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== BYPASS || bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_edge: hv=%b hit=%b way=%0d multi=%b want hv=1 hit=%b way=0 multi=0",
                     bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit, BYPASS);
        end
        drive_lookup(3, 13'h0055);
        step();
        idle_inputs();
        checks++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 1'b0 || bus.multi_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_followup: hit=%b way=%0d multi=%b want 1 0 0", bus.hit, bus.hit_way, bus.multi_hit);
        end
    endtask

    task automatic test_random_traffic();
        bit h;
        bit m;
        int wy;
        for (int i = 0; i < 300; i++) begin
            bit do_l = ($urandom_range(0, 3) != 0);
            bit do_w = ($urandom_range(0, 1) == 1);
            int la = $urandom_range(0, 3);
            int wa = ($urandom_range(0, 1) == 1) ? la : $urandom_range(0, 3);
            int ww = $urandom_range(0, WAYS - 1);
            bit wi = ($urandom_range(0, 3) == 0);
            bit [TWIDTH-1:0] lt = TWIDTH'($urandom_range(0, 3));
            bit [TWIDTH-1:0] wt = TWIDTH'($urandom_range(0, 3));
            idle_inputs();
            if (do_l) drive_lookup(la, lt);
            if (do_w) drive_write(ww, wa, wi, wt);
            if (BYPASS && do_w) model_write(ww, wa, wi, wt);
            model_lookup(la, lt, h, wy, m);
            if (!BYPASS && do_w) model_write(ww, wa, wi, wt);
            step();
            checks++;
            if (do_l) begin
                if (bus.hit_valid !== 1'b1 || bus.hit !== h || bus.hit_way !== WWIDTH'(h ? wy : 0) || bus.multi_hit !== m) begin
                    errors++;
                    $display("FAIL rand_lookup %0d set %0d tag %0d: hv=%b hit=%b way=%0d multi=%b want 1 %b %0d %b",
                             i, la, lt, bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit, h, h ? wy : 0, m);
                end
            end else if (bus.hit_valid !== 1'b0 || bus.hit !== 1'b0 || bus.hit_way !== '0 || bus.multi_hit !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle %0d: hv=%b hit=%b way=%0d multi=%b want all 0",
                         i, bus.hit_valid, bus.hit, bus.hit_way, bus.multi_hit);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_init();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_write($urandom_range(0, WAYS - 1), $urandom_range(0, DEPTH - 1), 1'b0, TWIDTH'($urandom_range(0, 3)));
            step();
        end
        drive_lookup(1, 13'h0001);
        reset_n = 1'b0;
        step();
        checks++;
        if (bus.ready !== 1'b0 || bus.hit_valid !== 1'b0 || bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL mid_init_reset: ready=%b hv=%b hit=%b want 0 0 0", bus.ready, bus.hit_valid, bus.hit);
        end
        reset_n = 1'b1;
        run_init("mid_init", 1'b1);
        for (int k = 0; k < init_wr_addr.size(); k++) begin
            drive_lookup(init_wr_addr[k], init_wr_tag[k]);
            step();
            checks++;
            if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0) begin
                errors++;
                $display("FAIL init_writes_ignored set %0d tag %0d: hv=%b hit=%b want 1 0",
                         init_wr_addr[k], init_wr_tag[k], bus.hit_valid, bus.hit);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_lookup();
        drive_write(0, 1, 1'b0, 13'h0777);
        step();
        idle_inputs();
        drive_lookup(1, 13'h0777);
        step();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lookup: hv=%b hit=%b want 1 1", bus.hit_valid, bus.hit);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (bus.hit_valid !== 1'b0 || bus.hit !== 1'b0 || bus.ready !== 1'b0 || bus.hit_way !== '0) begin
            errors++;
            $display("FAIL mid_lookup_reset: hv=%b hit=%b ready=%b way=%0d want 0 0 0 0",
                     bus.hit_valid, bus.hit, bus.ready, bus.hit_way);
        end
        idle_inputs();
        reset_n = 1'b1;
        run_init("mid_lookup", 1'b0);
        drive_lookup(1, 13'h0777);
        step();
        idle_inputs();
        checks++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL post_reinit_miss: hv=%b hit=%b want 1 0", bus.hit_valid, bus.hit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_back_to_back();
        test_single_hit();
        test_multi_hit();
        test_random_traffic();
        test_same_edge();
        test_reset_mid_init();
        test_reset_mid_lookup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tag_ram_lookup.md
TAG_RAM_LOOKUP -- requirements
Module: tag_ram_lookup

Interface
REQ-001 Parameter AWIDTH, default 3, is the set index width; DEPTH SHALL be 1 << AWIDTH.
REQ-002 Parameter TWIDTH, default 13, is the stored tag width, excluding the valid bit.
REQ-003 Parameter WAYS, default 2, is the number of ways; it SHALL be a power of two in the range 1..8, and WWIDTH SHALL be max(1, clog2(WAYS)).
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 lkp_valid  input  1  lookup request.
REQ-007 lkp_addr  input  AWIDTH  lookup set index.
REQ-008 lkp_tag  input  TWIDTH  tag to compare.
REQ-009 wr_en  input  1  tag write request.
REQ-010 wr_inv  input  1  when set with wr_en, clear the valid bit instead of writing the tag.
REQ-011 wr_way  input  WWIDTH  target way.
REQ-012 wr_addr  input  AWIDTH  target set index.
REQ-013 wr_tag  input  TWIDTH  tag written with valid=1.
REQ-014 ready  output  1  high when the block accepts lookups and writes.
REQ-015 hit_valid  output  1  one-cycle pulse: lookup result present.
REQ-016 hit  output  1  some valid way matched.
REQ-017 hit_way  output  WWIDTH  lowest-index matching way; 0 on miss.
REQ-018 multi_hit  output  1  more than one way matched; qualified by hit_valid.

Function
REQ-019 Storage SHALL be WAYS independent arrays of DEPTH entries, each entry {valid, tag}.
REQ-020 The FSM SHALL have two states: INIT and IDLE. Reset SHALL enter INIT with the init counter at 0.
REQ-021 In INIT, each cycle SHALL clear the valid bit of entry init_cnt in every way and then increment init_cnt.
REQ-022 When init_cnt = DEPTH-1, the FSM SHALL move to IDLE on that same edge, so INIT lasts exactly DEPTH cycles.
REQ-023 ready SHALL be 1 only in IDLE. Lookups and writes presented while ready=0 SHALL be ignored and never queued.
REQ-024 A lookup is accepted on an edge with lkp_valid=1 and ready=1. The array read SHALL be synchronous, with the index latched on that edge.
REQ-025 Results SHALL appear the following cycle: hit_valid=1 for exactly one cycle per accepted lookup.
REQ-026 Back-to-back lookups SHALL be sustained at one per cycle.
REQ-027 hit SHALL equal the OR over ways of (valid & stored tag == latched lkp_tag).
REQ-028 hit_way SHALL be the lowest matching way. multi_hit SHALL be set when two or more ways match.
REQ-029 When hit_valid=0, hit, hit_way and multi_hit SHALL be 0.
REQ-030 A write is accepted on an edge with wr_en=1 and ready=1. It SHALL update way wr_way at wr_addr:
  - wr_inv=0: valid=1, tag=wr_tag;
  - wr_inv=1: valid=0, tag unchanged.
REQ-031 A write and a lookup may be accepted on the same edge to different sets; both SHALL take effect.
REQ-032 For a write and a lookup to the same set on the same edge, the result SHALL follow Configuration.
REQ-033 Writes SHALL never alter another way or another set.

Reset
REQ-034 reset_n=0 sampled at an edge SHALL take effect regardless of state, including mid-INIT and mid-lookup:
  - INIT, init_cnt=0;
  - ready=0, hit_valid=0, hit=0, hit_way=0, multi_hit=0;
  - a lookup in flight SHALL be dropped, with no result pulse.
REQ-035 After reset, array contents SHALL be treated as invalid only once INIT has completed; no other array initialisation SHALL be relied on.

Configuration
REQ-036 Macro TAG_RAM_WR_BYPASS_EN, when defined: on a same-edge write and lookup to the same set, the lookup result SHALL reflect the written way's new {valid, tag}.
REQ-037 Without TAG_RAM_WR_BYPASS_EN, that lookup SHALL return the pre-write contents (read-before-write).
REQ-038 Either build SHALL leave all other ways' contents and results unaffected.

Verification (AWIDTH=3, TWIDTH=13, WAYS=2)
REQ-039 Reset then idle: ready=0 for exactly 8 cycles after reset_n rises; every lookup issued after that returns hit_valid=1, hit=0.
REQ-040 Write way1 set5 tag 0x0ABC, then look up set5 tag 0x0ABC: the next cycle gives hit=1, hit_way=1, multi_hit=0; tag 0x0ABD gives hit=0.
REQ-041 Write way0 and way1 set2 tag 0x1234, then look up: hit=1, hit_way=0, multi_hit=1. Then wr_inv way0 set2 and look up again: hit_way=1, multi_hit=0.
REQ-042 Same-edge write way0 set3 tag 0x0055 with lookup set3 tag 0x0055 on a freshly initialised RAM: hit=1 with the macro, hit=0 without.
REQ-043 Assert reset_n=0 at init_cnt=4, and separately the cycle after a lookup is accepted: no hit_valid pulse; INIT restarts and lasts 8 cycles; writes issued during INIT leave lookups returning hit=0.
